// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared definitions for the oversampling UART blocks
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic int calc_os_div(input int clk_fre, input int baud_rate);
    longint num;
    longint den;
    num = longint'(clk_fre) * 64'd1000000;
    den = longint'(baud_rate) * 64'd16;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversample tick generator, one-clock tick every OS_DIV clocks
module uart_os_tick #(
  parameter int OS_DIV = 27
) (
  input  logic i_clk_sys,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(OS_DIV);

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == CW'(OS_DIV - 1));

  always_ff @(posedge i_clk_sys) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampling UART receiver with majority vote,
// per-frame error flags and a one-entry valid/ready holding register
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FRE     = 50,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = PAR_NONE,
  parameter int STOP_BITS   = 1,
  parameter int OS_DIV      = calc_os_div(CLK_FRE, BAUD_RATE)
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst,
  input  logic                  i_uart_rx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun,
  output logic                  o_busy
);

  logic                  rx_meta, rx_sync, rx_prev;
  logic                  tick, start_edge;
  rx_state_e             state;
  logic [3:0]            os_cnt;
  logic [3:0]            bit_cnt;
  logic [1:0]            samp;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  all_zero, ferr_acc, perr_acc;
  logic                  maj, decide, wrap, last_stop;
  logic                  new_ferr, new_brk;

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = (state == ST_IDLE) && rx_prev && !rx_sync;

  // Clearing the tick counter on the start edge aligns the bit phase to the edge
  uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
    .i_clk_sys (i_clk_sys),
    .i_rst     (i_rst),
    .i_clr     (start_edge),
    .o_tick    (tick)
  );

  // Samples at os_cnt 7 and 8 are stored; the third is the live line at os_cnt 9
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
  assign decide    = tick && (os_cnt == 4'd9);
  assign wrap      = tick && (os_cnt == 4'd15);
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign new_ferr  = ferr_acc | ~maj;
  assign new_brk   = all_zero & ~maj;
  assign o_busy    = (state != ST_IDLE);

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      samp         <= '0;
      shreg        <= '0;
      all_zero     <= 1'b0;
      ferr_acc     <= 1'b0;
      perr_acc     <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (tick) begin
        os_cnt <= os_cnt + 4'd1;
        if (os_cnt == 4'd7) samp[0] <= rx_sync;
        if (os_cnt == 4'd8) samp[1] <= rx_sync;
      end
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state    <= ST_START;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            all_zero <= 1'b1;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && maj) state <= ST_IDLE;
          else if (wrap)     state <= ST_DATA;
        end
        ST_DATA: begin
          if (decide) begin
            shreg    <= {maj, shreg[DATA_WIDTH-1:1]};
            all_zero <= new_brk;
          end
          if (wrap) begin
            if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (decide) begin
            perr_acc <= (PARITY_MODE == PAR_EVEN) ? (^shreg ^ maj) : ~(^shreg ^ maj);
            all_zero <= new_brk;
          end
          if (wrap) state <= ST_STOP;
        end
        ST_STOP: begin
          if (decide) begin
            ferr_acc <= new_ferr;
            all_zero <= new_brk;
            // Completion does not wait for the end of the last stop bit
            if (last_stop) begin
              state <= new_brk ? ST_WAIT_IDLE : ST_IDLE;
              if (!o_valid || i_ready) begin
                o_data       <= shreg;
                o_parity_err <= perr_acc;
                o_frame_err  <= new_ferr;
                o_break      <= new_brk;
                o_valid      <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end
          end
          if (wrap) bit_cnt <= bit_cnt + 4'd1;
        end
        ST_WAIT_IDLE: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench: dut_a (no parity, 1 stop) and
// dut_b (even parity, 2 stops) driven in parallel from a bit-level line model
module tb_uart_rx_os;

  localparam int OSD  = 27;
  localparam int BITC = 16 * OSD;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] oa_data, ob_data;
  logic oa_valid, oa_pe, oa_fe, oa_brk, oa_ovr, oa_busy;
  logic ob_valid, ob_pe, ob_fe, ob_brk, ob_ovr, ob_busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   acc_a = 0, acc_b = 0, ovr_a = 0, ovr_b = 0, rise_a = 0;
  logic va_prev = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.CLK_FRE(50), .BAUD_RATE(115200), .DATA_WIDTH(8),
               .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .i_clk_sys(clk), .i_rst(rst_a), .i_uart_rx(rx_a), .o_data(oa_data),
    .o_valid(oa_valid), .i_ready(ready_a), .o_parity_err(oa_pe),
    .o_frame_err(oa_fe), .o_break(oa_brk), .o_overrun(oa_ovr), .o_busy(oa_busy));

  uart_rx_os #(.CLK_FRE(50), .BAUD_RATE(115200), .DATA_WIDTH(8),
               .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .i_clk_sys(clk), .i_rst(rst_b), .i_uart_rx(rx_b), .o_data(ob_data),
    .o_valid(ob_valid), .i_ready(ready_b), .o_parity_err(ob_pe),
    .o_frame_err(ob_fe), .o_break(ob_brk), .o_overrun(ob_ovr), .o_busy(ob_busy));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // inst 0 = dut_a (8N1), inst 1 = dut_b (8E2)
  function automatic exp_t model(input bit inst, input logic [7:0] d,
                                 input logic pbit, input logic [1:0] stops);
    exp_t m;
    m.data = d;
    m.pe   = inst && ((($countones(d) + int'(pbit)) % 2) == 1);
    m.fe   = !stops[0] || (inst && !stops[1]);
    m.brk  = (d == 8'h00) && (!inst || !pbit) && !stops[0] && (!inst || !stops[1]);
    return m;
  endfunction

  task automatic drive(input bit inst, input logic lvl, input int n, output int t_set);
    @(negedge clk);
    if (inst) rx_b = lvl;
    else      rx_a = lvl;
    t_set = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send(input bit inst, input logic [7:0] d, input logic pbit,
                      input logic [1:0] stops, input int gap, input bit expect_it,
                      output int t0);
    int t;
    if (expect_it) begin
      if (inst) q_b.push_back(model(inst, d, pbit, stops));
      else      q_a.push_back(model(inst, d, pbit, stops));
    end
    drive(inst, 1'b0, BITC, t0);
    for (int i = 0; i < 8; i++) drive(inst, d[i], BITC, t);
    if (inst) drive(inst, pbit, BITC, t);
    drive(inst, stops[0], BITC, t);
    if (inst) drive(inst, stops[1], BITC, t);
    if (gap > 0) drive(inst, 1'b1, gap * BITC, t);
  endtask

  always begin
    exp_t e;
    settle();
    if (!rst_a) begin
      if (oa_valid && !va_prev) rise_a = cyc;
      if (oa_ovr) ovr_a++;
      if (oa_valid && ready_a) begin
        acc_a++;
        check("expected_pending_a", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          check("frame_a", {oa_data, oa_pe, oa_fe, oa_brk}, e);
        end
      end
    end
    va_prev = oa_valid;
  end

  always begin
    exp_t e;
    settle();
    if (!rst_b) begin
      if (ob_ovr) ovr_b++;
      if (ob_valid && ready_b) begin
        acc_b++;
        check("expected_pending_b", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          check("frame_b", {ob_data, ob_pe, ob_fe, ob_brk}, e);
        end
      end
    end
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t, lat, n0;
    logic [7:0] d;
    logic pb;
    logic [1:0] st;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("reset_a", {oa_data, oa_valid, oa_pe, oa_fe, oa_brk, oa_ovr, oa_busy}, 0);
    check("reset_b", {ob_data, ob_valid, ob_pe, ob_fe, ob_brk, ob_ovr, ob_busy}, 0);

    fork
      begin
        send(0, 8'hA5, 1'b0, 2'b11, 1, 1, t0);
        lat = rise_a - t0;
        checks++;
        if (lat < 4161 - 2 || lat > 4161 + 2) begin
          errors++;
          $display("FAIL latency_a5: got %0d expected 4161 +-2", lat);
        end

        n0 = acc_a;
        drive(0, 1'b0, 5, t0);
        drive(0, 1'b1, 1, t);
        while (oa_busy && (cyc - t0) < 16 * OSD) settle();
        check("glitch_busy_idle", oa_busy, 0);
        drive(0, 1'b0, 4 * OSD, t0);
        drive(0, 1'b1, 1, t);
        while (oa_busy && (cyc - t0) < 16 * OSD) settle();
        check("short_start_busy_idle", oa_busy, 0);
        drive(0, 1'b1, BITC, t);
        check("false_start_no_frame", acc_a - n0, 0);

        @(negedge clk);
        ready_a = 1'b0;
        send(0, 8'h55, 1'b0, 2'b11, 0, 1, t0);
        send(0, 8'h3C, 1'b0, 2'b11, 1, 0, t0);
        settle();
        check("overrun_pulses", ovr_a, 1);
        check("overrun_hold", {oa_valid, oa_data}, {1'b1, 8'h55});
        @(negedge clk);
        ready_a = 1'b1;
        settle();
        settle();
        check("valid_drop_after_accept", oa_valid, 0);

        drive(0, 1'b0, BITC, t);
        drive(0, 1'b1, BITC, t);
        drive(0, 1'b0, BITC / 2, t);
        @(negedge clk);
        rst_a = 1'b1;
        rx_a  = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("reset_mid_frame", {oa_data, oa_valid, oa_pe, oa_fe, oa_brk, oa_ovr, oa_busy}, 0);
        drive(0, 1'b1, 2 * BITC, t);
        send(0, 8'h42, 1'b0, 2'b11, 1, 1, t0);

        for (int i = 0; i < 3; i++) begin
          d  = 8'($urandom_range(0, 255));
          st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
          send(0, d, 1'b0, st, 1, 1, t0);
        end
      end
      begin
        send(1, 8'h03, 1'b1, 2'b11, 1, 1, t0);
        send(1, 8'h03, 1'b0, 2'b11, 1, 1, t0);
        send(1, 8'h5A, 1'b0, 2'b01, 1, 1, t0);

        n0 = acc_b;
        q_b.push_back(model(1, 8'h00, 1'b0, 2'b00));
        drive(1, 1'b0, 20 * BITC, t);
        check("break_one_frame_low", acc_b - n0, 1);
        drive(1, 1'b1, 2 * BITC, t);
        check("break_one_frame_after", acc_b - n0, 1);

        for (int i = 0; i < 3; i++) begin
          d  = 8'($urandom_range(1, 255));
          pb = 1'($urandom_range(0, 1));
          st = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b11;
          send(1, d, pb, st, 1, 1, t0);
        end
      end
    join

    repeat (4) settle();
    check("queue_empty_a", q_a.size(), 0);
    check("queue_empty_b", q_b.size(), 0);
    check("overrun_total_a", ovr_a, 1);
    check("overrun_total_b", ovr_b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
